// File: rtl/event_pkg.sv
// Shared constants and FSM state type for the event encoder.
package event_pkg;

    localparam int unsigned N_REQ_DEF = 32;
    localparam int unsigned IDX_W_DEF = 5;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/prio_encode32.sv
// Combinational find-first-set over an N_REQ vector, searching upward from a start offset with wrap.
module prio_encode32
    import event_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] offset,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] first;

    // Rotate so the offset bit lands at position 0; the index add wraps because N_REQ is a power of two.
    always_comb begin
        rot   = N_REQ'({req, req} >> offset);
        first = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first = IDX_W'(i);
            end
        end
        index = first + offset;
        any   = |req;
    end

endmodule

// File: rtl/event_encoder.sv
// Sticky 32-to-5 event encoder with valid/ready output handshake.
// Define EVENT_ENCODER_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index-first.
module event_encoder
    import event_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_in,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pending,
    output logic             coalesced,
    input  logic             coalesced_clr
);

    state_t           state_q;
    state_t           state_d;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] grant_mask;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_index_q;
    logic             coalesced_q;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] offset;
    logic             sel_any;
    logic             load;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    // Pointer moves just past the most recently granted line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= sel_idx + IDX_W'(1);
        end
    end

    assign offset = ptr_q;
`else
    assign offset = '0;
`endif

    prio_encode32 #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req    (pending_q),
        .offset (offset),
        .index  (sel_idx),
        .any    (sel_any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and load decision; selection sees only registered pending.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        grant_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    load    = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (sel_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            grant_mask = N_REQ'(1) << sel_idx;
        end
    end

    // A request landing on the bit being granted keeps it pending for a later presentation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            coalesced_q <= 1'b0;
        end else begin
            pending_q   <= (pending_q & ~grant_mask) | req_in;
            out_valid_q <= (state_d == ST_HOLD);
            if (load) begin
                out_index_q <= sel_idx;
            end
            if (|(req_in & pending_q & ~grant_mask)) begin
                coalesced_q <= 1'b1;
            end else if (coalesced_clr) begin
                coalesced_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign pending   = pending_q;
    assign coalesced = coalesced_q;

endmodule

// File: tb/tb_event_encoder.sv
// Directed table-driven bench for event_encoder plus hand sequences for reset and rotation.
module tb_event_encoder;

    logic        clock;
    logic        reset;
    logic [31:0] req_in;
    logic        out_valid;
    logic [4:0]  out_index;
    logic        out_ready;
    logic [31:0] pending;
    logic        coalesced;
    logic        coalesced_clr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        rst;
        logic [31:0] req;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [4:0]  ei;
        logic [31:0] ep;
        logic        ec;
    } vec_t;

    vec_t vecs[$];

    event_encoder dut (
        .clock         (clock),
        .reset         (reset),
        .req_in        (req_in),
        .out_valid     (out_valid),
        .out_index     (out_index),
        .out_ready     (out_ready),
        .pending       (pending),
        .coalesced     (coalesced),
        .coalesced_clr (coalesced_clr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [4:0] ei,
                             input logic [31:0] ep, input logic ec);
        check({tag, "_valid"}, 32'(out_valid), 32'(ev));
        check({tag, "_index"}, 32'(out_index), 32'(ei));
        check({tag, "_pending"}, pending, ep);
        check({tag, "_coalesced"}, 32'(coalesced), 32'(ec));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] req, input logic rdy, input logic clr);
        req_in        = req;
        out_ready     = rdy;
        coalesced_clr = clr;
    endtask

    // Async reset pulse taken mid-cycle, away from any clock edge.
    task automatic pulse_reset();
        drive(32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic add(input logic rst, input logic [31:0] req, input logic rdy, input logic clr,
                       input logic ev, input logic [4:0] ei, input logic [31:0] ep, input logic ec);
        vec_t v;
        v.rst = rst; v.req = req; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0);

        // Single event, 2-edge latency, handshake back to idle
        add(1, 32'h0000_0400, 0, 0,  0,  0, 32'h0000_0400, 0);
        add(0, 32'h0000_0000, 0, 0,  1, 10, 32'h0000_0000, 0);
        add(0, 32'h0000_0000, 1, 0,  0, 10, 32'h0000_0000, 0);
        add(0, 32'h0000_0000, 0, 0,  0, 10, 32'h0000_0000, 0);
        // Multi-event back to back
        add(1, 32'h8000_0011, 1, 0,  0,  0, 32'h8000_0011, 0);
        add(0, 32'h0000_0000, 1, 0,  1,  0, 32'h8000_0010, 0);
        add(0, 32'h0000_0000, 1, 0,  1,  4, 32'h8000_0000, 0);
        add(0, 32'h0000_0000, 1, 0,  1, 31, 32'h0000_0000, 0);
        add(0, 32'h0000_0000, 1, 0,  0, 31, 32'h0000_0000, 0);
        // Backpressure and coalescing; set beats clear
        add(1, 32'h0000_0008, 0, 0,  0,  0, 32'h0000_0008, 0);
        add(0, 32'h0000_0000, 0, 0,  1,  3, 32'h0000_0000, 0);
        add(0, 32'h0000_0020, 0, 0,  1,  3, 32'h0000_0020, 0);
        add(0, 32'h0000_0020, 0, 1,  1,  3, 32'h0000_0020, 1);
        add(0, 32'h0000_0000, 0, 0,  1,  3, 32'h0000_0020, 1);
        add(0, 32'h0000_0000, 0, 1,  1,  3, 32'h0000_0020, 0);
        add(0, 32'h0000_0000, 1, 0,  1,  5, 32'h0000_0000, 0);
        add(0, 32'h0000_0000, 1, 0,  0,  5, 32'h0000_0000, 0);
        // Request on the bit granted in the same edge
        add(1, 32'h0000_0084, 0, 0,  0,  0, 32'h0000_0084, 0);
        add(0, 32'h0000_0000, 0, 0,  1,  2, 32'h0000_0080, 0);
        add(0, 32'h0000_0080, 1, 0,  1,  7, 32'h0000_0080, 0);
        add(0, 32'h0000_0000, 1, 0,  1,  7, 32'h0000_0000, 0);
        add(0, 32'h0000_0000, 1, 0,  0,  7, 32'h0000_0000, 0);

        repeat (2) @(posedge clock);
        #1;
        check_all("reset_held", 1'b0, 5'd0, 32'h0, 1'b0);
        reset = 1'b0;
        tick();
        check_all("reset_released", 1'b0, 5'd0, 32'h0, 1'b0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            drive(vecs[i].req, vecs[i].rdy, vecs[i].clr);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].ec);
        end

        // Async reset while holding with everything pending
        pulse_reset();
        drive(32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        check("async_fill_pending", pending, 32'hFFFF_FFFF);
        drive(32'h0, 1'b0, 1'b0);
        tick();
        check_all("async_hold", 1'b1, 5'd0, 32'hFFFF_FFFE, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_mid", 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        reset = 1'b0;
        drive(32'h0, 1'b1, 1'b0);
        repeat (3) tick();
        check_all("async_after", 1'b0, 5'd0, 32'h0, 1'b0);

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
        // Rotation: pointer at 1 with pending {1,0}, late bit 1 re-request
        pulse_reset();
        drive(32'h1, 1'b0, 1'b0);
        tick();
        check("rr_p0", pending, 32'h1);
        drive(32'h0, 1'b0, 1'b0);
        tick();
        check_all("rr_g0", 1'b1, 5'd0, 32'h0, 1'b0);
        drive(32'h3, 1'b0, 1'b0);
        tick();
        check_all("rr_fill", 1'b1, 5'd0, 32'h3, 1'b0);
        drive(32'h0, 1'b1, 1'b0);
        tick();
        check_all("rr_g1", 1'b1, 5'd1, 32'h1, 1'b0);
        drive(32'h2, 1'b0, 1'b0);
        tick();
        check_all("rr_rereq", 1'b1, 5'd1, 32'h3, 1'b0);
        drive(32'h0, 1'b1, 1'b0);
        tick();
        check_all("rr_g0b", 1'b1, 5'd0, 32'h2, 1'b0);
        tick();
        check_all("rr_g1b", 1'b1, 5'd1, 32'h0, 1'b0);
        tick();
        check_all("rr_idle", 1'b0, 5'd1, 32'h0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
